// File: rtl/peak_qualifier_if.sv
// Envelope-stage flags/extremes and thresholds in, qualified amplitude/period/activity out.
interface peak_qualifier_if #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 16
);
    logic             posen;
    logic             negen;
    logic [WIDTH-1:0] maxin;
    logic [WIDTH-1:0] minin;
    logic [WIDTH-1:0] thr_on;
    logic [WIDTH-1:0] thr_off;
    logic [WIDTH-1:0] amp;
    logic             amp_valid;
    logic [CNTW-1:0]  period;
    logic             per_valid;
    logic             active;
    logic             timeout;

    modport master (
        output posen, negen, maxin, minin, thr_on, thr_off,
        input  amp, amp_valid, period, per_valid, active, timeout
    );

    modport slave (
        input  posen, negen, maxin, minin, thr_on, thr_off,
        output amp, amp_valid, period, per_valid, active, timeout
    );
endinterface

// File: rtl/peak_qualifier.sv
// Turning-point detector: pairs peaks with troughs for amplitude, times peak-to-peak period,
// and qualifies signal presence through a hysteresis FSM.
module peak_qualifier #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 16,
    parameter int QUAL  = 2
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    peak_qualifier_if.slave bus
);
    typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_e;
    typedef enum logic [1:0] {S_IDLE, S_PEND, S_ACTIVE} state_e;

    localparam logic [CNTW-1:0] CNT_MAX = '1;
    localparam logic [3:0]      QUAL_C  = 4'(QUAL);

    dir_e             dir_q, dir_d;
    state_e           state_q;
    logic [CNTW-1:0]  cnt_q, cnt_d, period_q;
    logic [WIDTH-1:0] pk_q, amp_q;
    logic [3:0]       qcnt_q;
    logic             have_pk_q, have_prev_q;
    logic             amp_valid_q, per_valid_q;
    logic             timeout_q, timeout_d, active_q;
    logic             peak, trough, tmo_set, amp_on, amp_off;

    always_comb begin
        dir_d = dir_q;
        if (bus.posen && !bus.negen)      dir_d = DIR_UP;
        else if (bus.negen && !bus.posen) dir_d = DIR_DOWN;
    end

    // Leaving NONE is never an event: only UP<->DOWN reversals count.
    assign peak   = (dir_q == DIR_UP)   && (dir_d == DIR_DOWN);
    assign trough = (dir_q == DIR_DOWN) && (dir_d == DIR_UP);

    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (peak) begin
            cnt_d     = CNTW'(1);
            timeout_d = 1'b0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CNT_MAX) timeout_d = 1'b1;
        end
    end

    assign tmo_set = timeout_d && !timeout_q;
    assign amp_on  = (amp_q >= bus.thr_on);
    assign amp_off = (amp_q <  bus.thr_off);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dir_q       <= DIR_NONE;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
            pk_q        <= '0;
            amp_q       <= '0;
            period_q    <= '0;
            have_pk_q   <= 1'b0;
            have_prev_q <= 1'b0;
            amp_valid_q <= 1'b0;
            per_valid_q <= 1'b0;
        end else begin
            dir_q       <= dir_d;
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
            amp_valid_q <= 1'b0;
            per_valid_q <= 1'b0;
            if (peak) begin
                pk_q        <= bus.maxin;
                have_pk_q   <= 1'b1;
                have_prev_q <= 1'b1;
                if (have_prev_q) begin
                    period_q    <= cnt_q;
                    per_valid_q <= 1'b1;
                end
            end
            // A trough with no pending peak has nothing to pair with.
            if (trough && have_pk_q) begin
                amp_q       <= (pk_q >= bus.minin) ? pk_q - bus.minin : '0;
                amp_valid_q <= 1'b1;
                have_pk_q   <= 1'b0;
            end
        end
    end

    // Hysteresis FSM; a fresh timeout overrides any amplitude seen in the same cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            qcnt_q   <= '0;
            active_q <= 1'b0;
        end else if (tmo_set) begin
            state_q  <= S_IDLE;
            qcnt_q   <= '0;
            active_q <= 1'b0;
        end else if (amp_valid_q) begin
            case (state_q)
                S_IDLE: begin
                    if (amp_on) begin
                        if (QUAL == 1) begin
                            state_q  <= S_ACTIVE;
                            qcnt_q   <= '0;
                            active_q <= 1'b1;
                        end else begin
                            state_q <= S_PEND;
                            qcnt_q  <= 4'd1;
                        end
                    end
                end
                S_PEND: begin
                    if (!amp_on) begin
                        state_q <= S_IDLE;
                        qcnt_q  <= '0;
                    end else if ((qcnt_q + 4'd1) >= QUAL_C) begin
                        state_q  <= S_ACTIVE;
                        qcnt_q   <= '0;
                        active_q <= 1'b1;
                    end else begin
                        qcnt_q <= qcnt_q + 4'd1;
                    end
                end
                S_ACTIVE: begin
                    if (amp_off) begin
                        state_q  <= S_IDLE;
                        active_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    qcnt_q   <= '0;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.amp       = amp_q;
    assign bus.amp_valid = amp_valid_q;
    assign bus.period    = period_q;
    assign bus.per_valid = per_valid_q;
    assign bus.active    = active_q;
    assign bus.timeout   = timeout_q;
endmodule
